// File: rtl/lut_sxx_chain_if.sv
// rtl/lut_sxx_chain_if.sv - user/config bus for the chained LUT block
interface lut_sxx_chain_if #(
  parameter int ADDR_W = 7,
  parameter int STAGES = 2
);
  logic [ADDR_W-1:0] addr;
  logic              ce;
  logic              config_en;
  logic              config_in;
  logic              config_out;
  logic              config_done;
  logic [STAGES-1:0] stage_out;
  logic              out;

  modport master (
    output addr, ce, config_en, config_in,
    input  config_out, config_done, stage_out, out
  );

  modport slave (
    input  addr, ce, config_en, config_in,
    output config_out, config_done, stage_out, out
  );
endinterface

// File: rtl/lut_sxx_chain.sv
// rtl/lut_sxx_chain.sv - serially configured chain of LUT stages
// Stage k feeds its output in as the index MSB of stage k+1.
module lut_sxx_chain #(
  parameter int INPUTS   = 4,
  parameter int STAGES   = 2,
  parameter int MEM_SIZE = 2**INPUTS
) (
  input  logic            clk,
  input  logic            rst_n,
  lut_sxx_chain_if.slave  sxx
);
  localparam int ADDR_W = INPUTS + (STAGES-1)*(INPUTS-1);
  localparam int CFG_W  = STAGES*MEM_SIZE + 1;
  localparam int CNT_W  = $clog2(CFG_W+1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CFG_W);

  logic [CFG_W-1:0]  cfg_q, cfg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              out_q, out_d;
  logic [STAGES-1:0] stage_raw;

  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_stage
    localparam int TBL_HI = (STAGES-k)*MEM_SIZE - 1;
    logic [MEM_SIZE-1:0] tbl;
    logic [INPUTS-1:0]   idx;
    assign tbl = cfg_q[TBL_HI -: MEM_SIZE];
    if (k == 0) begin : g_first
      assign idx = sxx.addr[ADDR_W-1 -: INPUTS];
    end else begin : g_next
      assign idx = {stage_raw[k-1], sxx.addr[ADDR_W-INPUTS-(k-1)*(INPUTS-1)-1 -: INPUTS-1]};
    end
    assign stage_raw[k] = tbl[idx];
  end

  always_comb begin
    cfg_d  = cfg_q;
    cnt_d  = cnt_q;
    out_d  = out_q;
    if (sxx.config_en) begin
      cfg_d = {sxx.config_in, cfg_q[CFG_W-1:1]};
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end
    done_d = (cnt_d == CNT_MAX);
    // A shift on the same edge wins over the output register capture.
    if (sxx.ce && done_q && !sxx.config_en) out_d = stage_raw[STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      out_q  <= 1'b0;
    end else begin
      cfg_q  <= cfg_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
      out_q  <= out_d;
    end
  end

  assign sxx.config_out  = cfg_q[0];
  assign sxx.config_done = done_q;
  assign sxx.stage_out   = done_q ? stage_raw : '0;
  assign sxx.out         = !done_q ? 1'b0 :
                           (cfg_q[CFG_W-1] ? out_q : stage_raw[STAGES-1]);
endmodule

// File: tb/tb_lut_sxx_chain.sv
// tb/tb_lut_sxx_chain.sv - scoreboard bench for lut_sxx_chain (INPUTS=4, STAGES=2)
module tb_lut_sxx_chain;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lut_sxx_chain_if #(.ADDR_W(7), .STAGES(2)) bus ();
  lut_sxx_chain #(.INPUTS(4), .STAGES(2)) dut (.clk(clk), .rst_n(rst_n), .sxx(bus.slave));

  typedef struct {
    string       tag;
    int          sel;
    logic [63:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  localparam int SEL_DONE = 0, SEL_OUT = 1, SEL_STAGE = 2, SEL_CFGO = 3;
  localparam logic [32:0] LOAD_COMB = {1'b0, 16'h8000, 16'hFF00};
  localparam logic [32:0] LOAD_REG  = {1'b1, 16'h8000, 16'hFF00};
  localparam logic [32:0] LOAD_ONE  = {1'b0, 16'h8000, 16'hFF01};
  localparam logic [32:0] PATTERN   = 33'h1_2345_6789;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int sel, input logic [63:0] val);
    exp_t e;
    e.tag = tag; e.sel = sel; e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [63:0] obs;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.sel)
        SEL_DONE:  obs = 64'(bus.config_done);
        SEL_OUT:   obs = 64'(bus.out);
        SEL_STAGE: obs = 64'(bus.stage_out);
        default:   obs = 64'(bus.config_out);
      endcase
      check(e.tag, obs, e.val);
    end
  endtask

  task automatic expect_all_zero(input string tag);
    push_exp({tag, "_done"},  SEL_DONE,  0);
    push_exp({tag, "_out"},   SEL_OUT,   0);
    push_exp({tag, "_stage"}, SEL_STAGE, 0);
    push_exp({tag, "_cfgo"},  SEL_CFGO,  0);
    drain();
  endtask

  function automatic logic [1:0] model(input logic [32:0] cfg, input logic [6:0] a);
    logic s0, s1;
    s0 = cfg[16 + int'(a[6:3])];
    s1 = cfg[int'({s0, a[2:0]})];
    return {s1, s0};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.addr = '0; bus.ce = 1'b0; bus.config_en = 1'b0; bus.config_in = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic shift_bit(input logic b);
    bus.config_en = 1'b1;
    bus.config_in = b;
    @(posedge clk); #1;
    bus.config_en = 1'b0;
  endtask

  task automatic load(input logic [32:0] v);
    for (int i = 0; i < 33; i++) shift_bit(v[i]);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [32:0] ncfg;

    do_reset();
    expect_all_zero("reset");

    bus.addr = 7'h7F;
    for (int i = 0; i < 32; i++) shift_bit(LOAD_COMB[i]);
    push_exp("pre33_done", SEL_DONE, 0);
    push_exp("pre33_out", SEL_OUT, 0);
    push_exp("pre33_stage", SEL_STAGE, 0);
    drain();
    shift_bit(LOAD_COMB[32]);
    push_exp("at33_done", SEL_DONE, 1);
    push_exp("at33_out", SEL_OUT, 1);
    drain();

    for (int a = 0; a < 128; a++) begin
      logic [6:0] av;
      logic       hit;
      av = 7'(a);
      hit = (av[6:3] == 4'hF);
      bus.addr = av;
      push_exp($sformatf("comb_out_%0h", a), SEL_OUT, 64'(hit));
      push_exp($sformatf("comb_stage_%0h", a), SEL_STAGE, 64'({hit, hit}));
      #1;
      drain();
    end

    do_reset();
    load(LOAD_REG);
    bus.addr = 7'h00; bus.ce = 1'b1;
    tick();
    bus.addr = 7'h78;
    #1;
    push_exp("reg_before_edge", SEL_OUT, 0);
    drain();
    tick();
    push_exp("reg_after_edge", SEL_OUT, 1);
    drain();
    bus.ce = 1'b0; bus.addr = 7'h00;
    #1;
    push_exp("reg_hold_comb", SEL_OUT, 1);
    drain();
    tick();
    push_exp("reg_hold_edge", SEL_OUT, 1);
    drain();
    bus.ce = 1'b1;
    tick();
    push_exp("reg_ce_capture0", SEL_OUT, 0);
    drain();

    bus.addr = 7'h78;
    tick();
    push_exp("reg_capture1", SEL_OUT, 1);
    drain();
    bus.addr = 7'h00;
    ncfg = {1'b1, LOAD_REG[32:1]};
    shift_bit(1'b1);
    push_exp("shift_ce_out_hold", SEL_OUT, 1);
    push_exp("shift_ce_cfgo", SEL_CFGO, 64'(ncfg[0]));
    push_exp("shift_ce_stage0", SEL_STAGE, 64'(model(ncfg, 7'h00)));
    drain();
    bus.ce = 1'b0; bus.addr = 7'h7F;
    #1;
    push_exp("shift_ce_stage7f", SEL_STAGE, 64'(model(ncfg, 7'h7F)));
    push_exp("shift_ce_out_7f", SEL_OUT, 1);
    drain();

    do_reset();
    load(PATTERN);
    push_exp("replay_0", SEL_CFGO, 64'(PATTERN[0]));
    drain();
    for (int i = 1; i < 33; i++) begin
      shift_bit(1'b0);
      push_exp($sformatf("replay_%0d", i), SEL_CFGO, 64'(PATTERN[i]));
      drain();
    end
    shift_bit(1'b0);
    push_exp("replay_flushed", SEL_CFGO, 0);
    push_exp("replay_done_held", SEL_DONE, 1);
    drain();

    do_reset();
    bus.addr = 7'h7F;
    for (int i = 0; i < 20; i++) shift_bit(1'b1);
    push_exp("mid_done", SEL_DONE, 0);
    drain();
    #2;
    rst_n = 1'b0;
    #1;
    expect_all_zero("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) shift_bit(LOAD_ONE[i]);
    push_exp("reload32_done", SEL_DONE, 0);
    drain();
    shift_bit(LOAD_ONE[32]);
    push_exp("reload33_done", SEL_DONE, 1);
    push_exp("reload_out", SEL_OUT, 1);
    push_exp("reload_cfgo", SEL_CFGO, 1);
    push_exp("reload_stage", SEL_STAGE, 64'(model(LOAD_ONE, 7'h7F)));
    drain();
    #2;
    rst_n = 1'b0;
    #1;
    expect_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/lut_sxx_chain.md
LUT_SXX_CHAIN -- requirements
Module: lut_sxx_chain

Interface
REQ-001 Parameter INPUTS, default 4, address width of every LUT stage; legal range 2..6.
REQ-002 Parameter STAGES, default 2, number of chained LUT stages; legal range 2..8.
REQ-003 Parameter MEM_SIZE, default 2**INPUTS, truth-table bits per stage; not overridden.
REQ-004 Derived ADDR_W = INPUTS + (STAGES-1)*(INPUTS-1); derived CFG_W = STAGES*MEM_SIZE + 1.
REQ-005 clk  input  1  single clock for configuration and user logic; all flops use the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 addr  input  ADDR_W  user address; the MSB INPUTS bits feed stage 0, then INPUTS-1 bits per stage downward.
REQ-008 ce  input  1  clock enable for the optional output register.
REQ-009 config_en  input  1  serial configuration shift enable.
REQ-010 config_in  input  1  serial configuration data bit.
REQ-011 config_out  output  1  serial scan-out (cfg[0]) for daisy-chaining blocks.
REQ-012 config_done  output  1  high once CFG_W bits have been shifted since reset.
REQ-013 stage_out  output  STAGES  combinational output of each stage; bit k = stage k.
REQ-014 out  output  1  block output, combinational or registered per mode bit.

Function
REQ-015 The block SHALL hold a CFG_W-bit register cfg; bit CFG_W-1 = reg_mode, bits [STAGES*MEM_SIZE-1:0] = truth tables.
REQ-016 When config_en=1 at a clk edge, cfg SHALL shift right by one: cfg <= {config_in, cfg[CFG_W-1:1]}; the first bit shifted in ends at cfg[0] after CFG_W shifts.
REQ-017 A bit counter SHALL increment per shift and saturate at CFG_W; config_done = (count == CFG_W), registered.
REQ-018 Shifts after saturation SHALL continue to shift cfg, with config_done held at 1.
REQ-019 Stage 0 SHALL use table cfg[STAGES*MEM_SIZE-1 -: MEM_SIZE], indexed by addr[ADDR_W-1 -: INPUTS].
REQ-020 Stage k>=1 SHALL use table cfg[(STAGES-k)*MEM_SIZE-1 -: MEM_SIZE], indexed by {stage_out[k-1], addr[ADDR_W-INPUTS-(k-1)*(INPUTS-1)-1 -: INPUTS-1]}, with stage_out[k-1] as the index MSB.
REQ-021 Stage output SHALL equal table[index]; the last stage consumes addr[INPUTS-2:0].
REQ-022 While config_done=0, stage_out and out SHALL be forced to 0.
REQ-023 reg_mode=0: out = stage_out[STAGES-1] combinationally.
REQ-024 reg_mode=1: out = out_q, where out_q <= stage_out[STAGES-1] on an edge with ce=1, config_done=1, config_en=0; otherwise out_q holds.
REQ-025 With reg_mode=1, latency from addr to out is exactly one enabled clk edge.
REQ-026 If config_en and ce are both 1 at the same edge, the shift SHALL occur and out_q SHALL hold.
REQ-027 With reg_mode=0, out SHALL follow live cfg contents, including mid-reconfiguration after config_done=1; software must treat out as invalid during a reload.

Reset
REQ-028 rst_n=0 SHALL asynchronously clear cfg, the counter, config_done, and out_q to 0; config_out, stage_out, and out therefore read 0.
REQ-029 Reset asserted mid-shift SHALL discard the partial load; a full CFG_W-bit reload is then required.
REQ-030 Reset deassertion SHALL be synchronous to clk externally; no internal synchronizer is required.

Verification (INPUTS=4, STAGES=2, CFG_W=33)
REQ-031 Reset, then 32 shifts -> config_done=0 and out=0; the 33rd shift -> config_done=1 on that edge.
REQ-032 Load reg_mode=0, stage0 table 16'h8000 (AND4), stage1 table 16'hFF00 (pass the MSB) -> out=1 only for addr[6:3]=4'hF; stage_out[0] matches.
REQ-033 Load reg_mode=1 with the same tables; set addr=7'h78 with ce=1 -> out=0 before the edge and 1 after the edge; with ce=0, out holds across an addr change.
REQ-034 Shift pattern 0x1_2345_6789 LSB-first, then 33 more shifts of 0 -> config_out replays the original bits in order.
REQ-035 Assert rst_n=0 after 20 shifts -> all outputs 0 immediately without a clk edge; config_done stays 0 until 33 new shifts.
REQ-036 config_en=1 and ce=1 on the same edge with reg_mode=1 -> cfg shifts and out_q is unchanged.
